rand_delay_gen: RTL

- Consumer end of the LFSR random-number interface. Drives `next` and samples the 8-bit `rnd` stream.
- Turns random bytes into a bounded random timestamp increment for new PDES events.
- Sits between the LFSR and the event-generation logic of each simulation core.
- Requester asks for a future event time; the block returns cur_time + MIN_DELAY + random offset over a valid/ready handshake.

---
 rtl/rand_delay_gen.sv | 105 ++++++++++
 1 files changed

// File: rtl/rand_delay_gen.sv
// rand_delay_gen: draws NBYTES bytes from the LFSR byte stream and returns
// cur_time + MIN_DELAY + masked random offset, saturated to TIME_W bits,
// over a valid/ready handshake.
module rand_delay_gen #(
    parameter int unsigned TIME_W    = 16,
    parameter int unsigned DELAY_W   = 8,
    parameter int unsigned MIN_DELAY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    output logic              req_ready,
    input  logic [TIME_W-1:0] cur_time,
    output logic              next,
    input  logic [7:0]        rnd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [TIME_W-1:0] out_time,
    output logic [15:0]       issued_cnt
);

    localparam int unsigned NBYTES = (DELAY_W + 7) / 8;
    localparam int unsigned ACC_W  = NBYTES * 8;
    localparam int unsigned CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    // Two guard bits: base, MIN_DELAY and offset can each approach the widest operand.
    localparam int unsigned SUM_W  = ((TIME_W > DELAY_W) ? TIME_W : DELAY_W) + 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        CALC  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t             state;
    logic [TIME_W-1:0]  base_r;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   byte_cnt;
    logic [SUM_W-1:0]   sum_c;
    logic               sat_c;

    // Candidate event time and overflow detection from the latched base and drawn bytes.
    always_comb begin
        sum_c = SUM_W'(base_r) + SUM_W'(MIN_DELAY) + SUM_W'(acc[DELAY_W-1:0]);
        sat_c = |sum_c[SUM_W-1:TIME_W];
    end

    // Request/fetch/compute/output sequencer with registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            next       <= 1'b0;
            out_valid  <= 1'b0;
            out_time   <= '0;
            issued_cnt <= '0;
            base_r     <= '0;
            acc        <= '0;
            byte_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    next <= 1'b0;
                    if (req_ready && req) begin
                        base_r    <= cur_time;
                        acc       <= '0;
                        byte_cnt  <= '0;
                        req_ready <= 1'b0;
                        next      <= 1'b1;
                        state     <= FETCH;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                FETCH: begin
                    // Shift in the byte presented while next is high; first byte ends up on top.
                    acc <= ACC_W'({acc, rnd});
                    if (byte_cnt == CNT_W'(NBYTES - 1)) begin
                        next  <= 1'b0;
                        state <= CALC;
                    end else begin
                        byte_cnt <= byte_cnt + CNT_W'(1);
                    end
                end
                CALC: begin
                    out_time  <= sat_c ? '1 : sum_c[TIME_W-1:0];
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid  <= 1'b0;
                        issued_cnt <= issued_cnt + 16'd1;
                        req_ready  <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
